// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control path: opcodes, instruction field
// positions, data-source selects and sequencer states.
package cpu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_ALU  = 3'b010;
  localparam logic [2:0] OP_PUSH = 3'b011;
  localparam logic [2:0] OP_POP  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_JC   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_HI      = 15;
  localparam int OP_LO      = 13;
  localparam int ALU_HI     = 12;
  localparam int ALU_LO     = 8;
  localparam int RD_BIT     = 8;
  localparam int ALU_RD_BIT = 7;
  localparam int IMM_HI     = 7;
  localparam int IMM_LO     = 0;

  // Source of the register write data
  localparam logic [1:0] SRC_IMM   = 2'd0;
  localparam logic [1:0] SRC_ALU   = 2'd1;
  localparam logic [1:0] SRC_STACK = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder: turns the IR plus carry/stack status into
// the strobe set, write-data source, jump decision and fault/halt requests.
module control_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        carry,
  input  logic        stack_full,
  input  logic        stack_empty,
  output logic        reg_we,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        drive_alu_sel,
  output logic        drive_reg_sel,
  output logic        reg_sel,
  output logic        latch_carry,
  output logic [1:0]  din_src,
  output logic [4:0]  alu_code,
  output logic [7:0]  imm,
  output logic        jump_taken,
  output logic        halt,
  output logic        fault
);

  logic [2:0] op;

  assign op       = ir[OP_HI:OP_LO];
  assign alu_code = ir[ALU_HI:ALU_LO];
  assign imm      = ir[IMM_HI:IMM_LO];

  // A faulting PUSH/POP drives nothing, not even the selects
  always_comb begin
    reg_we        = 1'b0;
    stack_push    = 1'b0;
    stack_pop     = 1'b0;
    drive_alu_sel = 1'b0;
    drive_reg_sel = 1'b0;
    reg_sel       = 1'b0;
    latch_carry   = 1'b0;
    din_src       = SRC_IMM;
    jump_taken    = 1'b0;
    halt          = 1'b0;
    fault         = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LDI: begin
        reg_we        = 1'b1;
        drive_reg_sel = 1'b1;
        reg_sel       = ir[RD_BIT];
        din_src       = SRC_IMM;
      end
      OP_ALU: begin
        reg_we        = 1'b1;
        drive_alu_sel = 1'b1;
        drive_reg_sel = 1'b1;
        reg_sel       = ir[ALU_RD_BIT];
        din_src       = SRC_ALU;
        latch_carry   = 1'b1;
      end
      OP_PUSH: begin
        if (stack_full) begin
          fault = 1'b1;
        end else begin
          stack_push    = 1'b1;
          drive_alu_sel = 1'b1;
        end
      end
      OP_POP: begin
        if (stack_empty) begin
          fault = 1'b1;
        end else begin
          reg_we        = 1'b1;
          stack_pop     = 1'b1;
          drive_reg_sel = 1'b1;
          reg_sel       = ir[RD_BIT];
          din_src       = SRC_STACK;
        end
      end
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = carry;
      OP_HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: FETCH/DECODE/EXEC loop over a synchronous program ROM,
// driving the datapath strobes for one cycle in EXEC.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  output logic [4:0]      alu_sel,
  output logic            reg_sel,
  output logic            reg_we,
  output logic [7:0]      reg_din,
  output logic            stack_push,
  output logic            stack_pop,
  output logic [7:0]      stack_din,
  input  logic [7:0]      alu_output,
  input  logic            alu_carry,
  input  logic            stack_full,
  input  logic            stack_empty,
  input  logic [7:0]      stack_dout,
  output logic            halted,
  output logic            fault
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [15:0]     ir;
  logic            carry_flag;
  logic [4:0]      alu_sel_q;
  logic            reg_sel_q;

  logic            dec_reg_we, dec_stack_push, dec_stack_pop;
  logic            dec_drive_alu_sel, dec_drive_reg_sel, dec_reg_sel;
  logic            dec_latch_carry, dec_jump_taken, dec_halt, dec_fault;
  logic [1:0]      dec_din_src;
  logic [4:0]      dec_alu_code;
  logic [7:0]      dec_imm;

  control_decoder u_decoder (
    .ir            (ir),
    .carry         (carry_flag),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .reg_we        (dec_reg_we),
    .stack_push    (dec_stack_push),
    .stack_pop     (dec_stack_pop),
    .drive_alu_sel (dec_drive_alu_sel),
    .drive_reg_sel (dec_drive_reg_sel),
    .reg_sel       (dec_reg_sel),
    .latch_carry   (dec_latch_carry),
    .din_src       (dec_din_src),
    .alu_code      (dec_alu_code),
    .imm           (dec_imm),
    .jump_taken    (dec_jump_taken),
    .halt          (dec_halt),
    .fault         (dec_fault)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      carry_flag <= 1'b0;
      alu_sel_q  <= '0;
      reg_sel_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      alu_sel_q <= alu_sel;
      reg_sel_q <= reg_sel;
      if (state == S_DECODE) ir <= instr;
      if (state == S_EXEC && dec_latch_carry) carry_flag <= alu_carry;
    end
  end

  // Strobes come straight from the state register so reset kills them at once
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    alu_sel    = alu_sel_q;
    reg_sel    = reg_sel_q;
    reg_we     = 1'b0;
    reg_din    = '0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    stack_din  = '0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        reg_we     = dec_reg_we;
        stack_push = dec_stack_push;
        stack_pop  = dec_stack_pop;
        if (dec_drive_alu_sel) alu_sel = dec_alu_code;
        if (dec_drive_reg_sel) reg_sel = dec_reg_sel;
        if (dec_reg_we) begin
          case (dec_din_src)
            SRC_IMM:   reg_din = dec_imm;
            SRC_ALU:   reg_din = alu_output;
            SRC_STACK: reg_din = stack_dout;
            default:   reg_din = '0;
          endcase
        end
        if (dec_stack_push) stack_din = alu_output;
        if (dec_fault) begin
          state_nxt = S_FAULT;
        end else if (dec_halt) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
          pc_nxt    = dec_jump_taken ? PC_W'(dec_imm) : pc + PC_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign halted = (state == S_HALT);
  assign fault  = (state == S_FAULT);

endmodule
